// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Inter-stage pipeline register with valid/ready handshake, flush,
//            optional skid entry and control gating on invalid heads.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int A_W    = 5,
  parameter int PC_W   = 32,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [A_W-1:0]    in_a3,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [A_W-1:0]    out_a3,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        occupancy
);

  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [A_W-1:0]    r_m_a3;
  logic [PC_W-1:0]   r_m_pc;

  logic w_accept;
  logic w_consume;

  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_m_valid & out_ready;

  // Bubbles must never carry live control bits downstream.
  assign out_valid = r_m_valid;
  assign out_data  = r_m_data;
  assign out_ctrl  = r_m_ctrl & {CTRL_W{r_m_valid}};
  assign out_a3    = r_m_a3 & {A_W{r_m_valid}};
  assign out_pc    = r_m_pc;

  generate
    if (SKID == 0) begin : g_single
      assign in_ready  = ~r_m_valid | out_ready;
      assign occupancy = {1'b0, r_m_valid};

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_m_valid <= 1'b0;
          r_m_data  <= '0;
          r_m_ctrl  <= '0;
          r_m_a3    <= '0;
          r_m_pc    <= '0;
        end else begin
          if (flush)
            r_m_valid <= 1'b0;
          else if (w_accept)
            r_m_valid <= 1'b1;
          else if (w_consume)
            r_m_valid <= 1'b0;

          if (w_accept && !flush) begin
            r_m_data <= in_data;
            r_m_ctrl <= in_ctrl;
            r_m_a3   <= in_a3;
            r_m_pc   <= in_pc;
          end
        end
      end
    end else begin : g_skid
      logic              r_s_valid;
      logic [DATA_W-1:0] r_s_data;
      logic [CTRL_W-1:0] r_s_ctrl;
      logic [A_W-1:0]    r_s_a3;
      logic [PC_W-1:0]   r_s_pc;

      // Ready depends only on held state, breaking the combinational path.
      assign in_ready  = ~r_s_valid;
      assign occupancy = {1'b0, r_m_valid} + {1'b0, r_s_valid};

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_m_valid <= 1'b0;
          r_m_data  <= '0;
          r_m_ctrl  <= '0;
          r_m_a3    <= '0;
          r_m_pc    <= '0;
          r_s_valid <= 1'b0;
          r_s_data  <= '0;
          r_s_ctrl  <= '0;
          r_s_a3    <= '0;
          r_s_pc    <= '0;
        end else if (flush) begin
          r_m_valid <= 1'b0;
          r_s_valid <= 1'b0;
        end else if (w_consume && r_s_valid) begin
          r_m_data  <= r_s_data;
          r_m_ctrl  <= r_s_ctrl;
          r_m_a3    <= r_s_a3;
          r_m_pc    <= r_s_pc;
          r_s_valid <= 1'b0;
        end else if (w_accept && (!r_m_valid || w_consume)) begin
          r_m_valid <= 1'b1;
          r_m_data  <= in_data;
          r_m_ctrl  <= in_ctrl;
          r_m_a3    <= in_a3;
          r_m_pc    <= in_pc;
        end else if (w_accept) begin
          r_s_valid <= 1'b1;
          r_s_data  <= in_data;
          r_s_ctrl  <= in_ctrl;
          r_s_a3    <= in_a3;
          r_s_pc    <= in_pc;
        end else if (w_consume) begin
          r_m_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Checks SKID=1 and SKID=0 instances against bounded FIFO models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
    logic [4:0]  a;
    logic [31:0] p;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic [4:0]  in_a3 = '0;
  logic [31:0] in_pc = '0;

  logic        rdy1, ov1, rdy0, ov0;
  logic [63:0] d1, d0;
  logic [7:0]  c1, c0;
  logic [4:0]  a1, a0;
  logic [31:0] p1, p0;
  logic [1:0]  occ1, occ0;

  int errors = 0;
  int checks = 0;
  entry_t q1[$];
  entry_t q0[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_a3(in_a3), .in_pc(in_pc),
    .out_valid(ov1), .out_ready(out_ready), .out_data(d1), .out_ctrl(c1),
    .out_a3(a1), .out_pc(p1), .occupancy(occ1)
  );

  pipe_stage_reg #(.SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_a3(in_a3), .in_pc(in_pc),
    .out_valid(ov0), .out_ready(out_ready), .out_data(d0), .out_ctrl(c0),
    .out_a3(a0), .out_pc(p0), .occupancy(occ0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_inst(input string n, input logic rdy_e, input int sz, input entry_t hd,
                            input logic ir, input logic ov, input logic [1:0] occ,
                            input logic [63:0] d, input logic [7:0] c, input logic [4:0] a,
                            input logic [31:0] p);
    check({n, ".in_ready"}, 64'(ir), 64'(rdy_e));
    check({n, ".out_valid"}, 64'(ov), 64'(sz > 0));
    check({n, ".occupancy"}, 64'(occ), 64'(sz));
    check({n, ".out_ctrl"}, 64'(c), (sz > 0) ? 64'(hd.c) : 64'd0);
    check({n, ".out_a3"}, 64'(a), (sz > 0) ? 64'(hd.a) : 64'd0);
    if (sz > 0) begin
      check({n, ".out_data"}, d, hd.d);
      check({n, ".out_pc"}, 64'(p), 64'(hd.p));
    end
  endtask

  // One clock cycle from a negedge: check outputs, advance the model, clock.
  task automatic step();
    logic   e1, e0;
    entry_t cur, h1, h0;
    #2;
    e1  = (q1.size() < 2);
    e0  = (q0.size() == 0) || out_ready;
    h1  = (q1.size() > 0) ? q1[0] : '0;
    h0  = (q0.size() > 0) ? q0[0] : '0;
    cur = '{d: in_data, c: in_ctrl, a: in_a3, p: in_pc};
    check_inst("skid1", e1, q1.size(), h1, rdy1, ov1, occ1, d1, c1, a1, p1);
    check_inst("skid0", e0, q0.size(), h0, rdy0, ov0, occ0, d0, c0, a0, p0);
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() > 0 && out_ready) void'(q1.pop_front());
      if (in_valid && e1) q1.push_back(cur);
      if (q0.size() > 0 && out_ready) void'(q0.pop_front());
      if (in_valid && e0) q0.push_back(cur);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] pc);
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    in_ctrl  = 8'($urandom) | 8'h01;
    in_a3    = 5'($urandom) | 5'h01;
    in_pc    = pc;
  endtask

  initial begin
    // Reset held with a live-looking offer on the inputs.
    in_valid = 1'b1;
    in_ctrl  = 8'hFF;
    repeat (2) @(negedge clk);
    #2;
    check("rst.out_valid1", 64'(ov1), 64'd0);
    check("rst.out_ctrl1", 64'(c1), 64'd0);
    check("rst.in_ready1", 64'(rdy1), 64'd1);
    check("rst.occ1", 64'(occ1), 64'd0);
    check("rst.out_data1", d1, 64'd0);
    check("rst.out_pc1", 64'(p1), 64'd0);
    check("rst.in_ready0", 64'(rdy0), 64'd1);
    check("rst.out_ctrl0", 64'(c0), 64'd0);
    @(negedge clk);

    reset     = 1'b1;
    out_ready = 1'b1;
    in_data   = 64'h1234;
    in_pc     = 32'h3000;
    in_ctrl   = 8'h3C;
    in_a3     = 5'd7;
    step();
    #2;
    check("first.out_valid", 64'(ov1), 64'd1);
    check("first.out_data", d1, 64'h1234);
    @(negedge clk);

    // Streaming at full rate.
    offer(32'h3000); step();
    offer(32'h3004); step();
    offer(32'h3008); step();
    in_valid = 1'b0;
    step(); step();

    // Back-pressure: A then B, B held for three stall cycles.
    out_ready = 1'b0;
    offer(32'h4000); step();
    offer(32'h4004); step();
    step(); step();
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();

    // Flush with two held entries and a live offer.
    out_ready = 1'b0;
    offer(32'h5000); step();
    offer(32'h5004); step();
    offer(32'h5008);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(); step();

    // Asynchronous reset between edges with one entry held.
    out_ready = 1'b0;
    offer(32'h6000);
    in_ctrl = 8'hA5;
    step();
    in_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("arst.out_valid1", 64'(ov1), 64'd0);
    check("arst.out_ctrl1", 64'(c1), 64'd0);
    check("arst.occ1", 64'(occ1), 64'd0);
    check("arst.out_valid0", 64'(ov0), 64'd0);
    check("arst.out_ctrl0", 64'(c0), 64'd0);
    q1.delete();
    q0.delete();
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom);
      in_data   = {$urandom, $urandom};
      in_ctrl   = 8'($urandom);
      in_a3     = 5'($urandom);
      in_pc     = $urandom;
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(15) == 0);
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register, the next generation of the fixed EX/MEM latch. It carries a generic data payload, a control bundle and a PC between any two pipeline stages, adds a valid/ready handshake with stall and flush, and has an optional skid entry so that back-pressure does not create a combinational ready path through the stage. Control bits leave the block forced to zero whenever no valid instruction is held, so bubbles can never write the register file or data memory.

## Interface
- DATA_W, 64: width of the data payload (e.g. {Result, RD2}).
- CTRL_W, 8: width of the control bundle (e.g. {DMWE, DataWBSel, RegWE, SLCtrl}).
- A_W, 5: destination register address width.
- PC_W, 32: PC width.
- SKID, 1: 0 = single entry, ready passes through combinationally; 1 = two entries (main + skid), in_ready is registered.

- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all held entries and any entry offered this cycle.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  block accepts the upstream entry this cycle.
- in_data  in  DATA_W  payload.
- in_ctrl  in  CTRL_W  control bundle.
- in_a3  in  A_W  destination register.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream consumes the output entry this cycle.
- out_data  out  DATA_W  payload of the head entry.
- out_ctrl  out  CTRL_W  control of the head entry, all-zero when out_valid = 0.
- out_a3  out  A_W  head destination, 0 when out_valid = 0.
- out_pc  out  PC_W  head PC (not gated).
- occupancy  out  2  number of held entries (0..1 for SKID=0, 0..2 for SKID=1).

## Operation
- Accept = in_valid & in_ready; consume = out_valid & out_ready.
- SKID=0: one register, valid bit V. in_ready = ~V | out_ready. On accept, main register loads {in_data, in_ctrl, in_a3, in_pc} and V <= 1; on consume without accept, V <= 0. Payload registers load only on accept (hold otherwise).
- SKID=1: main entry M (head) and skid entry S. in_ready = ~S_valid (registered state only, no dependency on out_ready).
  - Accept, M empty or consumed, S empty: entry goes to M.
  - Accept, M held and not consumed: entry goes to S.
  - Consume with S valid: S moves to M, S empties (an accept in the same cycle is impossible, since in_ready = 0).
  - Consume, S empty, no accept: M empties.
- Order is strict FIFO; no entry is dropped or duplicated except by flush.
- flush has priority over everything: on the clock edge with flush = 1, all valid bits clear, the offered entry is discarded, and the consume still counts as taken by downstream. Payload registers hold their contents.
- Gating: out_ctrl = M_ctrl & {CTRL_W{M_valid}}; out_a3 likewise.
- occupancy = M_valid + S_valid.

## Timing
- Reset (reset = 0, asynchronous): all valid bits 0; all payload, ctrl, a3 and PC registers 0; out_valid 0; out_ctrl 0; out_a3 0; out_data 0; out_pc 0; occupancy 0; in_ready 1 (both modes). The block leaves reset on the first clk edge after reset rises.
- Latency: an entry accepted at edge N appears on the outputs after edge N, i.e. one cycle of latency, with no bypass from input to output.
- Throughput: one entry per cycle while out_ready = 1 in both modes.
- SKID=1, out_ready falls with M held: the next accepted entry goes to S and in_ready drops after that edge. At most one extra entry is absorbed.
- Reset asserted mid-transfer empties the block immediately, without waiting for a clock edge.

## Test plan
- Reset: hold reset = 0 with in_valid = 1 and in_ctrl = 0xFF -> out_valid = 0, out_ctrl = 0x00, in_ready = 1, occupancy = 0. Release reset, drive in_data = 0x1234 and in_pc = 0x3000 -> after one edge out_valid = 1 and out_data = 0x1234.
- Streaming: out_ready = 1, feed PCs 0x3000, 0x3004, 0x3008 on consecutive cycles -> they appear in order, one per cycle, each one cycle after its accept.
- Back-pressure (SKID=1): out_ready = 0 while sending A then B -> occupancy = 2, in_ready = 0, head = A. Raise out_ready -> A, then B, then in_ready = 1.
- Back-pressure (SKID=0): out_ready = 0 with M held -> in_ready = 0 in the same cycle and the upstream entry is not lost after 3 stall cycles.
- Flush: occupancy = 2 and in_valid = 1, pulse flush for one cycle -> next cycle out_valid = 0, out_ctrl = 0, occupancy = 0, and the offered entry never appears.
- Asynchronous reset mid-stream: drop reset between clock edges with occupancy = 1 -> out_valid and out_ctrl go to 0 before the next edge.
